// File: rtl/fa16_rev_pkg.sv
// ---------------------------------------------------------------------------
// fa16_rev_pkg
// Shared definitions for the 16-bit reversible adder sequencer:
//   FA16_W            operand width
//   fa16_seq_state_t  sequencer states (IDLE, FWD, SPACER, BWD, RESP)
//   dr16_t            dual-rail 16-bit value {pos, neg}
//   to_dr16()         builds a valid dual-rail codeword from a single-rail value
// ---------------------------------------------------------------------------
package fa16_rev_pkg;

    localparam int FA16_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FWD    = 3'd1,
        SPACER = 3'd2,
        BWD    = 3'd3,
        RESP   = 3'd4
    } fa16_seq_state_t;

    typedef struct packed {
        logic [FA16_W-1:0] pos;
        logic [FA16_W-1:0] neg;
    } dr16_t;

    // A valid dual-rail codeword carries the value on pos and its complement on neg.
    function automatic dr16_t to_dr16(input logic [FA16_W-1:0] v);
        dr16_t r;
        r.pos = v;
        r.neg = ~v;
        return r;
    endfunction

endpackage

// File: rtl/fa16_rev_seq_chk.sv
// ---------------------------------------------------------------------------
// dual_rail_chk
// Flags any bit position whose two rails are not complementary
// (both 0 = spacer/null, both 1 = illegal).
//   pos, neg : rails under test (W bits each)
//   err      : 1 when at least one pair is not complementary
// ---------------------------------------------------------------------------
module dual_rail_chk #(
    parameter int W = 16
) (
    input  logic [W-1:0] pos,
    input  logic [W-1:0] neg,
    output logic         err
);

    assign err = |(~(pos ^ neg));

endmodule

// File: rtl/fa16_rev_seq.sv
// ---------------------------------------------------------------------------
// fa16_rev_seq
// Sequencer and dual-rail driver for the 16-bit reversible adder wrapper.
// Takes a single-rail operand pair, drives the adder forward, samples sum and
// carry, re-drives it backward from the sampled result, samples the recovered
// operand and returns the result plus a round-trip check.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE. out_valid is 1 only in RESP, and all
// out_* hold steady there until out_ready completes the transfer; the block
// then spends at least one cycle in IDLE before accepting the next request.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready           request handshake; in_a, in_b, in_cin operands
//   out_valid/out_ready         response handshake
//   out_sum, out_cout           forward result (positive rails)
//   out_rt_ok                   recovered a and c0 match the request
//   out_rail_err                non-complementary sample seen (optional check)
//   fwd_en, bwd_en              wrapper tri-state enables
//   drv_*                       dual-rail drive to the wrapper
//   smp_*                       dual-rail samples from the wrapper
//   dbg_state                   current sequencer state
//
// Build option: define FA16_REV_RAILCHECK_EN to generate the rail
// complementarity check; otherwise out_rail_err is tied to 0.
// ---------------------------------------------------------------------------
module fa16_rev_seq
    import fa16_rev_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FA16_W-1:0] in_a,
    input  logic [FA16_W-1:0] in_b,
    input  logic              in_cin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FA16_W-1:0] out_sum,
    output logic              out_cout,
    output logic              out_rt_ok,
    output logic              out_rail_err,
    output logic              fwd_en,
    output logic              bwd_en,
    output logic [FA16_W-1:0] drv_a,
    output logic [FA16_W-1:0] drv_a_n,
    output logic [FA16_W-1:0] drv_b,
    output logic [FA16_W-1:0] drv_b_n,
    output logic              drv_c0,
    output logic              drv_c0_n,
    output logic [FA16_W-1:0] drv_s,
    output logic [FA16_W-1:0] drv_s_n,
    output logic              drv_c15,
    output logic              drv_c15_n,
    input  logic [FA16_W-1:0] smp_s,
    input  logic [FA16_W-1:0] smp_s_n,
    input  logic              smp_c15,
    input  logic              smp_c15_n,
    input  logic [FA16_W-1:0] smp_ab,
    input  logic [FA16_W-1:0] smp_ab_n,
    input  logic              smp_c0b,
    input  logic              smp_c0b_n,
    output fa16_seq_state_t   dbg_state
);

    localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);

    fa16_seq_state_t   state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [FA16_W-1:0] a_q, a_d;
    logic [FA16_W-1:0] b_q, b_d;
    logic              cin_q, cin_d;
    logic [FA16_W-1:0] s_q, s_d;
    logic              c15_q, c15_d;
    logic [FA16_W-1:0] ab_q, ab_d;
    logic              c0b_q, c0b_d;

    logic  last_cnt;
    dr16_t dr_a, dr_b, dr_s;

    assign last_cnt  = (cnt_q == LAST_CNT);
    assign dr_a      = to_dr16(a_q);
    assign dr_b      = to_dr16(b_q);
    assign dr_s      = to_dr16(s_q);
    assign dbg_state = state_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        cin_d     = cin_q;
        s_d       = s_q;
        c15_d     = c15_q;
        ab_d      = ab_q;
        c0b_d     = c0b_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_sum   = '0;
        out_cout  = 1'b0;
        out_rt_ok = 1'b0;
        fwd_en    = 1'b0;
        bwd_en    = 1'b0;
        drv_a     = '0;
        drv_a_n   = '0;
        drv_b     = '0;
        drv_b_n   = '0;
        drv_c0    = 1'b0;
        drv_c0_n  = 1'b0;
        drv_s     = '0;
        drv_s_n   = '0;
        drv_c15   = 1'b0;
        drv_c15_n = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    cin_d   = in_cin;
                    cnt_d   = '0;
                    state_d = FWD;
                end
            end
            FWD: begin
                fwd_en   = 1'b1;
                drv_a    = dr_a.pos;
                drv_a_n  = dr_a.neg;
                drv_b    = dr_b.pos;
                drv_b_n  = dr_b.neg;
                drv_c0   = cin_q;
                drv_c0_n = ~cin_q;
                if (last_cnt) begin
                    // Samples are taken at the edge closing the final settle cycle.
                    s_d     = smp_s;
                    c15_d   = smp_c15;
                    state_d = SPACER;
                end else begin
                    cnt_d = 8'(cnt_q + 8'd1);
                end
            end
            SPACER: begin
                // All rails stay at the null spacer for one cycle between directions.
                cnt_d   = '0;
                state_d = BWD;
            end
            BWD: begin
                bwd_en    = 1'b1;
                drv_s     = dr_s.pos;
                drv_s_n   = dr_s.neg;
                drv_c15   = c15_q;
                drv_c15_n = ~c15_q;
                // b is still needed by the adder to recover a in reverse.
                drv_b     = dr_b.pos;
                drv_b_n   = dr_b.neg;
                if (last_cnt) begin
                    ab_d    = smp_ab;
                    c0b_d   = smp_c0b;
                    state_d = RESP;
                end else begin
                    cnt_d = 8'(cnt_q + 8'd1);
                end
            end
            RESP: begin
                out_valid = 1'b1;
                out_sum   = s_q;
                out_cout  = c15_q;
                out_rt_ok = (ab_q == a_q) && (c0b_q == cin_q);
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            s_q     <= '0;
            c15_q   <= 1'b0;
            ab_q    <= '0;
            c0b_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            s_q     <= s_d;
            c15_q   <= c15_d;
            ab_q    <= ab_d;
            c0b_q   <= c0b_d;
        end
    end

`ifdef FA16_REV_RAILCHECK_EN
    logic fwd_chk_err, bwd_chk_err;
    logic rail_err_q, rail_err_d;

    dual_rail_chk #(.W(FA16_W + 1)) u_fwd_chk (
        .pos ({smp_s,   smp_c15}),
        .neg ({smp_s_n, smp_c15_n}),
        .err (fwd_chk_err)
    );

    dual_rail_chk #(.W(FA16_W + 1)) u_bwd_chk (
        .pos ({smp_ab,   smp_c0b}),
        .neg ({smp_ab_n, smp_c0b_n}),
        .err (bwd_chk_err)
    );

    // Sticky across one operation; only the latch edges are checked because
    // the rails are allowed to be mid-transition while the adder settles.
    always_comb begin
        rail_err_d = rail_err_q;
        if (state_q == IDLE) begin
            rail_err_d = 1'b0;
        end else if (state_q == FWD && last_cnt && fwd_chk_err) begin
            rail_err_d = 1'b1;
        end else if (state_q == BWD && last_cnt && bwd_chk_err) begin
            rail_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rail_err_q <= 1'b0;
        end else begin
            rail_err_q <= rail_err_d;
        end
    end

    assign out_rail_err = (state_q == RESP) && rail_err_q;
`else
    // Negative sample rails have no consumer without the rail check.
    logic unused_neg_rails;
    assign unused_neg_rails = ^{smp_s_n, smp_c15_n, smp_ab_n, smp_c0b_n};
    assign out_rail_err     = 1'b0;
`endif

endmodule
